exu_alu_stage: RTL and testbench

- Execute-stage ALU sitting directly downstream of the operand-select block. Consumes its selected operands (alu_A / alu_B) plus op controls.
- Computes the RV64I integer result, including 32-bit W variants and the JAL/JALR link/target.
- Registers the result into the EX/MEM boundary behind a valid/ready handshake with a one-entry skid buffer, so upstream ready is a registered signal.

---
 rtl/exu_alu_stage.sv | 180 ++++++++++++++++++
 tb/tb_exu_alu_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_stage.sv
// exu_alu_stage
//   Execute-stage RV64I ALU. Computes the integer result (including W-form
//   ops) and the JAL/JALR link and target, then registers the payload into
//   the EX/MEM boundary behind a valid/ready handshake with one skid entry.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   flush_i             discard held and incoming work
//   in_valid_i/in_ready_o   upstream handshake (in_ready_o is registered)
//   alu_op_i, word_i, specinst_i, alu_A_i, alu_B_i, pc_i, rd_i   request
//   out_valid_o/out_ready_i downstream handshake
//   result_o, target_o, redirect_o, rd_o, specinst_o         registered payload
module exu_alu_stage #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_op_i,
  input  logic                  word_i,
  input  logic [2:0]            specinst_i,
  input  logic [DATA_WIDTH-1:0] alu_A_i,
  input  logic [DATA_WIDTH-1:0] alu_B_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [4:0]            rd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH-1:0] target_o,
  output logic                  redirect_o,
  output logic [4:0]            rd_o,
  output logic [2:0]            specinst_o
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [2:0] SI_JAL  = 3'd1;
  localparam logic [2:0] SI_JALR = 3'd2;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] target;
    logic        redirect;
    logic [4:0]  rd;
    logic [2:0]  spec;
  } payload_t;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] op_result(input logic [3:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] wa;
    logic [31:0]        w_res;
    logic [63:0]        d_res;
    logic [5:0]         shamt;
    logic               word_op;
    sa      = a;
    sb      = b;
    wa      = a[31:0];
    shamt   = word ? {1'b0, b[4:0]} : b[5:0];
    // W-forms exist only for add/sub/shifts; word_i on any other op is ignored
    word_op = word && (op inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA});
    case (op)
      OP_ADD:  w_res = a[31:0] + b[31:0];
      OP_SUB:  w_res = a[31:0] - b[31:0];
      OP_SLL:  w_res = a[31:0] << shamt[4:0];
      OP_SRL:  w_res = a[31:0] >> shamt[4:0];
      OP_SRA:  w_res = wa >>> shamt[4:0];
      default: w_res = '0;
    endcase
    case (op)
      OP_ADD:  d_res = a + b;
      OP_SUB:  d_res = a - b;
      OP_SLL:  d_res = a << shamt;
      OP_SLT:  d_res = {63'd0, sa < sb};
      OP_SLTU: d_res = {63'd0, a < b};
      OP_XOR:  d_res = a ^ b;
      OP_SRL:  d_res = a >> shamt;
      OP_SRA:  d_res = sa >>> shamt;
      OP_OR:   d_res = a | b;
      OP_AND:  d_res = a & b;
      default: d_res = '0;
    endcase
    return word_op ? sext32(w_res) : d_res;
  endfunction

  payload_t comp;
  logic [63:0] comp_sum;
  logic        accept;

  payload_t out_q, out_d, skid_q, skid_d;
  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;

  always_comb begin
    comp_sum  = alu_A_i + alu_B_i;
    comp.rd   = rd_i;
    comp.spec = specinst_i;
    if (specinst_i == SI_JAL || specinst_i == SI_JALR) begin
      comp.result   = pc_i + 64'd4;
      comp.target   = (specinst_i == SI_JALR) ? {comp_sum[63:1], 1'b0} : comp_sum;
      comp.redirect = 1'b1;
    end else begin
      comp.result   = op_result(alu_op_i, word_i, alu_A_i, alu_B_i);
      comp.target   = '0;
      comp.redirect = 1'b0;
    end
  end

  assign accept = in_valid_i && in_ready_q;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      // OUT is free this edge: the older skid entry has priority over new input.
      // Accept and a valid skid never coincide since in_ready is low then.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = comp;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = comp;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = out_q.result;
  assign target_o    = out_q.target;
  assign redirect_o  = out_valid_q & out_q.redirect;
  assign rd_o        = out_q.rd;
  assign specinst_o  = out_q.spec;

endmodule

// File: tb/tb_exu_alu_stage.sv
module tb_exu_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  alu_op_i;
  logic        word_i;
  logic [2:0]  specinst_i;
  logic [63:0] alu_A_i;
  logic [63:0] alu_B_i;
  logic [63:0] pc_i;
  logic [4:0]  rd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic [63:0] target_o;
  logic        redirect_o;
  logic [4:0]  rd_o;
  logic [2:0]  specinst_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] r;
    logic [63:0] t;
    logic        red;
    logic [4:0]  rd;
    logic [2:0]  sp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  exu_alu_stage #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_op_i(alu_op_i), .word_i(word_i), .specinst_i(specinst_i),
    .alu_A_i(alu_A_i), .alu_B_i(alu_B_i), .pc_i(pc_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .target_o(target_o), .redirect_o(redirect_o),
    .rd_o(rd_o), .specinst_o(specinst_o)
  );

  // Reference: RV64I semantics stated with integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic w, input logic [2:0] sp,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] pc, input logic [4:0] rd);
    exp_t   e;
    int     sh;
    int     s32;
    longint sa;
    longint sb;
    sa   = a;
    sb   = b;
    sh   = w ? int'(b[4:0]) : int'(b[5:0]);
    e.rd = rd;
    e.sp = sp;
    e.r  = 64'd0;
    if (w && (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd6 || op == 4'd7)) begin
      case (op)
        4'd0:    s32 = int'(a[31:0]) + int'(b[31:0]);
        4'd1:    s32 = int'(a[31:0]) - int'(b[31:0]);
        4'd2:    s32 = int'(a[31:0]) << sh;
        4'd6:    s32 = int'(a[31:0] >> sh);
        default: s32 = int'(a[31:0]) >>> sh;
      endcase
      sa  = longint'(s32);
      e.r = sa;
    end else begin
      case (op)
        4'd0: e.r = a + b;
        4'd1: e.r = a - b;
        4'd2: e.r = a << sh;
        4'd3: e.r = (sa < sb) ? 64'd1 : 64'd0;
        4'd4: e.r = (a < b) ? 64'd1 : 64'd0;
        4'd5: e.r = a ^ b;
        4'd6: e.r = a >> sh;
        4'd7: e.r = sa >>> sh;
        4'd8: e.r = a | b;
        4'd9: e.r = a & b;
        default: e.r = 64'd0;
      endcase
    end
    if (sp == 3'd1 || sp == 3'd2) begin
      e.t = a + b;
      if (sp == 3'd2) e.t = e.t & ~64'd1;
      e.r   = pc + 64'd4;
      e.red = 1'b1;
    end else begin
      e.t   = 64'd0;
      e.red = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic w, input logic [2:0] sp,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                       input logic [4:0] rd);
    in_valid_i = 1'b1;
    alu_op_i   = op;
    word_i     = w;
    specinst_i = sp;
    alu_A_i    = a;
    alu_B_i    = b;
    pc_i       = pc;
    rd_i       = rd;
  endtask

  task automatic run1(input string tag, input logic [3:0] op, input logic w, input logic [2:0] sp,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc,
                      input logic [63:0] er, input logic [63:0] et, input logic ered);
    out_ready_i = 1'b1;
    drive(op, w, sp, a, b, pc, 5'd7);
    tick();
    in_valid_i = 1'b0;
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_result"}, result_o, er);
    chk({tag, "_target"}, target_o, et);
    chk({tag, "_redirect"}, 64'(redirect_o), 64'(ered));
  endtask

  initial begin
    exp_t        e;
    logic        hold;
    logic [63:0] hold_r;
    logic [4:0]  hold_rd;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    alu_op_i = 4'd0; word_i = 1'b0; specinst_i = 3'd0;
    alu_A_i = 64'd0; alu_B_i = 64'd0; pc_i = 64'd0; rd_i = 5'd0;
    #12;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_result", result_o, 64'd0);
    chk("rst_redirect", 64'(redirect_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run1("add_wrap", 4'd0, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0, 1'b0);
    run1("addw", 4'd0, 1'b1, 3'd0, 64'h7FFF_FFFF, 64'd1, 64'd0,
         64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0);
    run1("sraw", 4'd7, 1'b1, 3'd0, 64'h8000_0000, 64'h21, 64'd0,
         64'hFFFF_FFFF_C000_0000, 64'd0, 1'b0);
    run1("sra63", 4'd7, 1'b0, 3'd0, 64'h8000_0000_0000_0000, 64'd63, 64'd0,
         64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    run1("srlw", 4'd6, 1'b1, 3'd0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd0,
         64'h0000_0000_0800_0000, 64'd0, 1'b0);
    run1("slt_neg", 4'd3, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd1, 64'd0, 1'b0);
    run1("xor_w_ignored", 4'd5, 1'b1, 3'd0, 64'hF0F0_0000_0000_0001, 64'h0F0F_0000_0000_0001,
         64'd0, 64'hFFFF_0000_0000_0000, 64'd0, 1'b0);
    run1("reserved", 4'd12, 1'b0, 3'd0, 64'd5, 64'd6, 64'd0, 64'd0, 64'd0, 1'b0);
    run1("jalr", 4'd0, 1'b0, 3'd2, 64'h2001, 64'd4, 64'h1000, 64'h1004, 64'h2004, 1'b1);
    chk("jalr_rd", 64'(rd_o), 64'd7);
    chk("jalr_spec", 64'(specinst_o), 64'd2);
    run1("jal", 4'd0, 1'b0, 3'd1, 64'h80, 64'h10, 64'h80, 64'h84, 64'h90, 1'b1);
    tick();
    chk("idle_valid", 64'(out_valid_o), 64'd0);
    chk("idle_redirect", 64'(redirect_o), 64'd0);

    // Back-pressure: 1+1, 2+2, 3+3 with downstream stalled
    out_ready_i = 1'b0;
    drive(4'd0, 1'b0, 3'd0, 64'd1, 64'd1, 64'd0, 5'd1);
    tick();
    chk("bp_ready1", 64'(in_ready_o), 64'd1);
    drive(4'd0, 1'b0, 3'd0, 64'd2, 64'd2, 64'd0, 5'd2);
    tick();
    chk("bp_ready2", 64'(in_ready_o), 64'd0);
    drive(4'd0, 1'b0, 3'd0, 64'd3, 64'd3, 64'd0, 5'd3);
    tick();
    chk("bp_stall_ready", 64'(in_ready_o), 64'd0);
    chk("bp_stall_result", result_o, 64'd2);
    out_ready_i = 1'b1;
    tick();
    chk("bp_out2", result_o, 64'd4);
    chk("bp_out2_valid", 64'(out_valid_o), 64'd1);
    tick();
    in_valid_i = 1'b0;
    chk("bp_out3", result_o, 64'd6);
    chk("bp_out3_rd", 64'(rd_o), 64'd3);
    tick();
    chk("bp_empty", 64'(out_valid_o), 64'd0);

    // Flush with OUT and SKID full and an input offered
    out_ready_i = 1'b0;
    drive(4'd0, 1'b0, 3'd0, 64'd10, 64'd10, 64'd0, 5'd4);
    tick();
    drive(4'd0, 1'b0, 3'd1, 64'd20, 64'd20, 64'd0, 5'd5);
    tick();
    chk("fl_full", 64'(in_ready_o), 64'd0);
    drive(4'd0, 1'b0, 3'd0, 64'd30, 64'd30, 64'd0, 5'd6);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_ready", 64'(in_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_ghost", 64'(out_valid_o), 64'd0);
    end

    // Async reset mid-stall with both entries full
    out_ready_i = 1'b0;
    drive(4'd0, 1'b0, 3'd1, 64'h100, 64'h8, 64'h40, 5'd9);
    tick();
    drive(4'd0, 1'b0, 3'd2, 64'h200, 64'h8, 64'h50, 5'd10);
    tick();
    in_valid_i = 1'b0;
    chk("rs_pre_redirect", 64'(redirect_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid", 64'(out_valid_o), 64'd0);
    chk("rs_ready", 64'(in_ready_o), 64'd1);
    chk("rs_result", result_o, 64'd0);
    chk("rs_target", target_o, 64'd0);
    chk("rs_redirect", 64'(redirect_o), 64'd0);
    chk("rs_rd", 64'(rd_o), 64'd0);
    chk("rs_spec", 64'(specinst_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run1("sltu_post_rst", 4'd4, 1'b0, 3'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
         64'd1, 64'd0, 1'b0);
    tick();

    // Randomized traffic against the scoreboard
    hold = 1'b0; hold_r = 64'd0; hold_rd = 5'd0;
    for (int c = 0; c < 600; c++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 59) == 0);
      alu_op_i    = 4'($urandom_range(0, 15));
      word_i      = 1'($urandom_range(0, 1));
      specinst_i  = 3'($urandom_range(0, 5));
      alu_A_i     = {$urandom, $urandom};
      alu_B_i     = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 127)) : {$urandom, $urandom};
      pc_i        = {$urandom, $urandom};
      rd_i        = 5'($urandom_range(0, 31));
      #1;
      chk("rnd_redir_gate", 64'(redirect_o & ~out_valid_o), 64'd0);
      chk("rnd_occupancy", 64'(out_valid_o), 64'(sb.size() > 0));
      chk("rnd_ready", 64'(in_ready_o), 64'(sb.size() < 2));
      if (hold) begin
        chk("rnd_stable_result", result_o, hold_r);
        chk("rnd_stable_rd", 64'(rd_o), 64'(hold_rd));
      end
      hold = 1'b0;
      if (flush_i) begin
        sb.delete();
      end else begin
        if (out_valid_o && out_ready_i) begin
          if (sb.size() == 0) begin
            chk("rnd_unexpected_out", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("rnd_result", result_o, e.r);
            chk("rnd_target", target_o, e.t);
            chk("rnd_redirect", 64'(redirect_o), 64'(e.red));
            chk("rnd_rd", 64'(rd_o), 64'(e.rd));
            chk("rnd_spec", 64'(specinst_o), 64'(e.sp));
          end
        end else if (out_valid_o) begin
          hold    = 1'b1;
          hold_r  = result_o;
          hold_rd = rd_o;
        end
        if (in_valid_i && in_ready_o)
          sb.push_back(model(alu_op_i, word_i, specinst_i, alu_A_i, alu_B_i, pc_i, rd_i));
      end
      @(negedge clk);
    end

    // Drain whatever is left, bounded
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      #1;
      if (out_valid_o) begin
        e = sb.pop_front();
        chk("drain_result", result_o, e.r);
        chk("drain_target", target_o, e.t);
      end
      @(negedge clk);
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    #1;
    chk("drain_idle", 64'(out_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
